btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer for the fetch stage, indexed by word-aligned PC[31:2].
- Provides a combinational lookup of the predicted target and a 2-bit direction counter.
- Takes one synchronous update per cycle from branch resolution.
- Adds per-entry valid bits, tree pseudo-LRU replacement, saturating-counter training and a multi-cycle flush sweep with a busy indication.

Parameters:
- SETS, 32, number of sets; power of two, ≥2.
- WAYS, 2, associativity; power of two, ≥2.
- ADDR_W, 30, word-address width of PCs and targets.
- Derived: IDX_W = $clog2(SETS); TAG_W = ADDR_W − IDX_W.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- flush  in  1  pulse; starts an invalidate sweep.
- busy  out  1  high while the flush sweep runs.
- lk_pc  in  ADDR_W  lookup PC (word address).
- lk_en  in  1  lookup is architecturally consumed; touches PLRU on hit.
- lk_hit  out  1  valid tag match in the indexed set.
- lk_target  out  ADDR_W  predicted target; 0 when lk_hit=0.
- lk_state  out  2  direction counter; 2'b01 when lk_hit=0.
- up_valid  in  1  update request.
- up_pc  in  ADDR_W  resolved branch PC.
- up_target  in  ADDR_W  resolved target.
- up_taken  in  1  resolved direction.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[1:0]. Index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W].
- Reset: all valid=0, all PLRU bits=0, flush counter=0, busy=0. Targets and counters are don't-care but must not produce X on outputs. Outputs settle to lk_hit=0, lk_target=0, lk_state=2'b01.
- Lookup is combinational, zero latency. A hit requires valid & tag equal. If more than one way matches (illegal), the lowest-index way wins. When busy=1, lk_hit is forced to 0.
- Updates are registered and visible to lookup the cycle after up_valid.
- Update hit:
  - Taken: ctr saturating increment (max 2'b11) and target overwritten.
  - Not taken: ctr saturating decrement (min 2'b00); target kept.
  - PLRU touched for the hit way.
- Update miss:
  - Taken: allocate the lowest-index invalid way, else the PLRU victim. Write valid=1, tag, target, ctr=2'b10, and touch PLRU for that way.
  - Not taken: no state change.
- PLRU: tree of WAYS−1 bits per set. A touch points every node on the path away from the touched way. The victim is found by following the node bits.
- Same-cycle lookup touch (lk_en & lk_hit) and update to the same set: the update's PLRU write wins. Different sets update independently.
- Flush FSM, states IDLE and SWEEP:
  - IDLE→SWEEP on flush: busy=1, counter=0.
  - In SWEEP, each cycle clears valid and PLRU bits for set[counter], then increments the counter.
  - After clearing set SETS−1, the next state is IDLE and busy drops; busy is high for exactly SETS cycles.
- While busy=1, up_valid is ignored and flush is ignored (no restart).
- An update in the same cycle as a flush assertion from IDLE is dropped.
- Reset mid-sweep returns immediately to IDLE with all entries invalid.

Decomposition:
- Package btb_pkg holds:
  - Counter constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Parametrised struct btb_entry_t {valid, tag, target, ctr}.
  - Flush state enum {IDLE, SWEEP}.
- Sub-module plru_tree #(WAYS): combinational; inputs are node bits and a touch way; outputs are updated node bits and the victim way. It is instantiated twice, once for the update path and once for the lookup path.

Test Plan:
- Reset, then lookup 30'h0000_0040 → lk_hit=0, lk_target=0, lk_state=01.
- Update taken pc=30'h100 target=30'h2A0; next cycle lookup 30'h100 → hit, target 2A0, state 10. Two more taken updates → state 11 and stays 11. Three not-taken updates → 10, 01, 00, then stays 00.
- Not-taken update on miss pc=30'h77 → next-cycle lookup misses; no way consumed.
- Capacity (WAYS=2, SETS=32):
  - Taken updates for pcs 30'h020, 30'h040 and 30'h060 all map to set 0.
  - After the third update, 30'h020 misses and 30'h040 and 30'h060 both hit.
  - Repeat with a lk_en lookup of 30'h020 between the 2nd and 3rd updates → 30'h040 is evicted instead.
- Populate 4 sets, pulse flush:
  - busy high for exactly 32 cycles; lk_hit=0 throughout; up_valid during the sweep has no effect.
  - After busy drops, all prior pcs miss.
  - A second flush pulse mid-sweep does not extend busy.
- Assert rst_l=0 at sweep cycle 10 → busy=0 asynchronously; all lookups miss after release.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
// Entry fields are sized for the widest word address; narrower tags are zero-extended.
package btb_pkg;

  localparam int BTB_ADDR_W = 30;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [BTB_ADDR_W-1:0] tag;
    logic [BTB_ADDR_W-1:0] target;
    logic [1:0]            ctr;
  } btb_entry_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } flush_state_t;

endpackage

// File: rtl/btb_assoc_plru_tree.sv
// Combinational tree pseudo-LRU: touching a way points every node on its path away from it,
// and the victim is found by following the node bits from the root (1 = go right).
module plru_tree #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-2:0]         nodes_in,
  input  logic [$clog2(WAYS)-1:0] touch,
  output logic [WAYS-2:0]         nodes_out,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int LEVELS = $clog2(WAYS);

  // Level l holds nodes (2^l - 1) .. (2^(l+1) - 2); the path node is picked by the way prefix.
  always_comb begin
    nodes_out = nodes_in;
    for (int l = 0; l < LEVELS; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if (k == int'(touch >> (LEVELS - l))) begin
          nodes_out[(1 << l) - 1 + k] = ~touch[LEVELS-1-l];
        end
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int l = 0; l < LEVELS; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if (k == int'(victim >> (LEVELS - l))) begin
          victim[LEVELS-1-l] = nodes_in[(1 << l) - 1 + k];
        end
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with zero-latency lookup, one update per cycle,
// tree pseudo-LRU replacement and a one-set-per-cycle flush sweep.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int SETS   = 32,
  parameter int WAYS   = 2,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              flush,
  output logic              busy,
  input  logic [ADDR_W-1:0] lk_pc,
  input  logic              lk_en,
  output logic              lk_hit,
  output logic [ADDR_W-1:0] lk_target,
  output logic [1:0]        lk_state,
  input  logic              up_valid,
  input  logic [ADDR_W-1:0] up_pc,
  input  logic [ADDR_W-1:0] up_target,
  input  logic              up_taken
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  btb_entry_t           ent  [SETS][WAYS];
  logic [WAYS-2:0]      plru [SETS];
  flush_state_t         state, state_nxt;
  logic [IDX_W-1:0]     flush_cnt;

  logic [IDX_W-1:0]      lk_idx, up_idx;
  logic [BTB_ADDR_W-1:0] lk_tag, up_tag;
  logic                  lk_match, up_hit, up_inv_any, up_go, up_write;
  logic [WAY_W-1:0]      lk_way, up_hit_way, up_inv_way, up_victim, up_way;
  logic [WAY_W-1:0]      lk_victim_unused;
  logic [WAYS-2:0]       lk_nodes, up_nodes;
  logic [1:0]            up_ctr;

  assign lk_idx = lk_pc[IDX_W-1:0];
  assign lk_tag = BTB_ADDR_W'(lk_pc[ADDR_W-1:IDX_W]);
  assign up_idx = up_pc[IDX_W-1:0];
  assign up_tag = BTB_ADDR_W'(up_pc[ADDR_W-1:IDX_W]);

  // Scanning from the top way down leaves the lowest matching way selected.
  always_comb begin
    lk_match = 1'b0;
    lk_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ent[lk_idx][w].valid && ent[lk_idx][w].tag == lk_tag) begin
        lk_match = 1'b1;
        lk_way   = WAY_W'(w);
      end
    end
  end

  assign lk_hit    = lk_match & ~busy;
  assign lk_target = lk_hit ? ent[lk_idx][lk_way].target[ADDR_W-1:0] : '0;
  assign lk_state  = lk_hit ? ent[lk_idx][lk_way].ctr : CTR_WNT;

  always_comb begin
    up_hit     = 1'b0;
    up_hit_way = '0;
    up_inv_any = 1'b0;
    up_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ent[up_idx][w].valid && ent[up_idx][w].tag == up_tag) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_W'(w);
      end
      if (!ent[up_idx][w].valid) begin
        up_inv_any = 1'b1;
        up_inv_way = WAY_W'(w);
      end
    end
  end

  assign up_way   = up_hit ? up_hit_way : (up_inv_any ? up_inv_way : up_victim);
  assign up_go    = up_valid && (state == IDLE) && !flush;
  assign up_write = up_go && (up_hit || up_taken);
  assign up_ctr   = ent[up_idx][up_hit_way].ctr;

  plru_tree #(.WAYS(WAYS)) u_plru_lk (
    .nodes_in  (plru[lk_idx]),
    .touch     (lk_way),
    .nodes_out (lk_nodes),
    .victim    (lk_victim_unused)
  );

  plru_tree #(.WAYS(WAYS)) u_plru_up (
    .nodes_in  (plru[up_idx]),
    .touch     (up_way),
    .nodes_out (up_nodes),
    .victim    (up_victim)
  );

  // The update's PLRU write is placed last so it overrides a lookup touch on the same set.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          ent[s][w] <= '0;
        end
      end
    end else if (state == SWEEP) begin
      plru[flush_cnt] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        ent[flush_cnt][w].valid <= 1'b0;
      end
    end else begin
      if (lk_en && lk_hit) begin
        plru[lk_idx] <= lk_nodes;
      end
      if (up_write) begin
        plru[up_idx] <= up_nodes;
        if (up_hit) begin
          if (up_taken) begin
            ent[up_idx][up_way].ctr    <= (up_ctr == CTR_ST) ? CTR_ST : up_ctr + 2'b01;
            ent[up_idx][up_way].target <= BTB_ADDR_W'(up_target);
          end else begin
            ent[up_idx][up_way].ctr    <= (up_ctr == CTR_SNT) ? CTR_SNT : up_ctr - 2'b01;
          end
        end else begin
          ent[up_idx][up_way] <= '{valid:  1'b1,
                                   tag:    up_tag,
                                   target: BTB_ADDR_W'(up_target),
                                   ctr:    CTR_WT};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (flush) state_nxt = SWEEP;
      SWEEP: if (flush_cnt == IDX_W'(SETS - 1)) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SWEEP);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      flush_cnt <= '0;
    end else if (state == IDLE) begin
      flush_cnt <= '0;
    end else begin
      flush_cnt <= flush_cnt + IDX_W'(1);
    end
  end

endmodule
